// File: rtl/seq_multiplier_pkg.sv
// Shared types and sizing helpers for the sequential shift-and-add multiplier.
package seq_multiplier_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_BITS  = 4;
  localparam int DEFAULT_CNT_W = $clog2(DEFAULT_BITS + 1);

  // Iteration counter width for a given operand width; must be able to hold BITS.
  function automatic int cnt_width(input int bits);
    return $clog2(bits + 1);
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Unsigned shift-and-add multiplier: one partial-product step per clock,
// BITS steps per operation, then a one-cycle completion flag.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int BITS = DEFAULT_BITS
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_start,
  output logic                o_finished,
  input  logic [BITS-1:0]     i_multiplicand,
  input  logic [BITS-1:0]     i_multiplier,
  output logic [2*BITS-1:0]   o_product
);

  localparam int                CNT_W     = cnt_width(BITS);
  localparam int                PW        = 2 * BITS + 1;
  localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(BITS - 1);

  state_t              r_state;
  state_t              w_next_state;
  logic [BITS-1:0]     r_a;
  logic [PW-1:0]       r_p;
  logic [CNT_W-1:0]    r_cnt;
  logic [2*BITS-1:0]   r_product;
  logic [BITS:0]       w_upper;
  logic [PW-1:0]       w_p_next;
  logic                w_last;

  assign w_last = (r_cnt == LAST_ITER);

  // One iteration: conditionally add A into the upper half, then shift right.
  always_comb begin
    w_upper = r_p[PW-1:BITS];
    if (r_p[0]) begin
      w_upper = r_p[PW-1:BITS] + {1'b0, r_a};
    end
    w_p_next = {1'b0, w_upper, r_p[BITS-1:1]};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: the default assignment before the case keeps this purely
  // combinational; a missing branch would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_next_state = ST_RUN;
      ST_RUN:  if (w_last)  w_next_state = ST_DONE;
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    o_finished = (r_state == ST_DONE);
    o_product  = r_product;
  end

  // Multiplier B lives in the low half of P, so only A needs its own latch.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_a       <= '0;
      r_p       <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_a   <= i_multiplicand;
            r_p   <= {{(BITS + 1){1'b0}}, i_multiplier};
            r_cnt <= '0;
          end
        end
        ST_RUN: begin
          r_p   <= w_p_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_product <= w_p_next[2*BITS-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: table-driven corners, multi-cycle
// sequences, exhaustive 4-bit sweep and random 8-bit pairs via scoreboards.
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start4 = 1'b0;
  logic [3:0]  a4 = '0;
  logic [3:0]  b4 = '0;
  logic        fin4;
  logic [7:0]  p4;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        fin8;
  logic [15:0] p8;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] q4[$];
  logic [15:0] q8[$];
  logic        fin4_prev = 1'b0;
  logic        fin8_prev = 1'b0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  seq_multiplier #(.BITS(4)) dut4 (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_start        (start4),
    .o_finished     (fin4),
    .i_multiplicand (a4),
    .i_multiplier   (b4),
    .o_product      (p4)
  );

  seq_multiplier #(.BITS(8)) dut8 (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_start        (start8),
    .o_finished     (fin8),
    .i_multiplicand (a8),
    .i_multiplier   (b8),
    .o_product      (p8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitors: every completion pops one expected product.
  always @(negedge clk) begin
    if (fin4) begin
      if (q4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done4_unexpected: got product %0d, expected no completion", p4);
      end else begin
        check("product4", 32'(p4), 32'(q4.pop_front()));
      end
    end
    if (fin4_prev) check("pulse4_width", 32'(fin4), 32'd0);
    fin4_prev <= fin4;
  end

  always @(negedge clk) begin
    if (fin8) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done8_unexpected: got product %0d, expected no completion", p8);
      end else begin
        check("product8", 32'(p8), 32'(q8.pop_front()));
      end
    end
    if (fin8_prev) check("pulse8_width", 32'(fin8), 32'd0);
    fin8_prev <= fin8;
  end

  task automatic run_op4(input logic [3:0] a, input logic [3:0] b, input logic [15:0] exp);
    int n;
    @(negedge clk);
    a4 = a; b4 = b; start4 = 1'b1;
    q4.push_back(exp);
    @(negedge clk);
    start4 = 1'b0;
    n = 0;
    while (!fin4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("latency4", n, 4);
  endtask

  task automatic run_op8(input logic [7:0] a, input logic [7:0] b);
    int n;
    @(negedge clk);
    a8 = a; b8 = b; start8 = 1'b1;
    q8.push_back(16'(a) * 16'(b));
    @(negedge clk);
    start8 = 1'b0;
    n = 0;
    while (!fin8 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("latency8", n, 8);
  endtask

  initial begin
    int n;
    vecs[0] = '{a: 4'd15, b: 4'd14, exp: 8'd210};
    vecs[1] = '{a: 4'd0,  b: 4'd15, exp: 8'd0};
    vecs[2] = '{a: 4'd15, b: 4'd0,  exp: 8'd0};
    vecs[3] = '{a: 4'd1,  b: 4'd1,  exp: 8'd1};
    vecs[4] = '{a: 4'd15, b: 4'd15, exp: 8'd225};

    repeat (3) @(negedge clk);
    check("reset_product4", 32'(p4), 32'd0);
    check("reset_finished4", 32'(fin4), 32'd0);
    check("reset_product8", 32'(p8), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_op4(vecs[i].a, vecs[i].b, 16'(vecs[i].exp));
    end

    // Start held high; operands change one cycle after the first latch.
    @(negedge clk);
    a4 = 4'd15; b4 = 4'd14; start4 = 1'b1;
    q4.push_back(16'd210);
    @(negedge clk);
    a4 = 4'd11; b4 = 4'd2;
    q4.push_back(16'd22);
    n = 0;
    while (!fin4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("b2b_first_latency", n, 4);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 2) start4 = 1'b0;
    end while (!fin4 && n < 20);
    start4 = 1'b0;
    check("b2b_spacing", n, 6);

    // Asynchronous reset two edges into RUN discards the operation.
    @(negedge clk);
    a4 = 4'd15; b4 = 4'd14; start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_reset_product4", 32'(p4), 32'd0);
    check("async_reset_finished4", 32'(fin4), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("post_reset_product4", 32'(p4), 32'd0);
    run_op4(4'd9, 4'd7, 16'd63);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op4(4'(a), 4'(b), 16'(a * b));
      end
    end

    run_op8(8'd255, 8'd255);
    run_op8(8'd0, 8'd200);
    repeat (24) run_op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));

    repeat (3) @(negedge clk);
    check("queue4_drained", q4.size(), 0);
    check("queue8_drained", q8.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
